// File: rtl/dot_prod_host.sv
// dot_prod_host: host-side driver for one dot-product kernel.
// It takes a (length, initial accumulator) command and loads `length` element
// pairs into the top of the kernel arrays (addresses DEPTH-len .. DEPTH-1).
// It then releases the kernel with its start index set to DEPTH-len, waits for
// the done flag (bounded by TIMEOUT) and returns the result on a valid/ready port.
module dot_prod_host #(
    parameter int DEPTH   = 1000,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 27,
    parameter int RES_W   = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    // command
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [RES_W-1:0]  cmd_acc,
    // element pairs
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    // result
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_err,
    // kernel control
    output logic              r_enable,
    output logic [ADDR_W-1:0] init_i_t_a,
    output logic [RES_W-1:0]  init_acc_t_a,
    output logic              controlArr,
    output logic              controlArrWEnable_a,
    output logic              controlArrWEnable_b,
    output logic [ADDR_W-1:0] controlArrAddr_a,
    output logic [ADDR_W-1:0] controlArrAddr_b,
    output logic [DATA_W-1:0] controlArrWData_a,
    output logic [DATA_W-1:0] controlArrWData_b,
    input  logic              w_enable,
    input  logic [RES_W-1:0]  result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  LAST_L  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   wr_ptr_q;
    logic [RES_W-1:0]  acc_q;
    logic [RES_W-1:0]  res_data_q;
    logic              res_err_q;
    logic [CNT_W-1:0]  run_cnt_q;

    logic cmd_fire, in_fire, len_bad, len_zero, last_write, run_timeout;

    // Handshake and condition decode shared by next-state and datapath logic
    always_comb begin
        cmd_fire    = (state_q == IDLE) && cmd_valid;
        in_fire     = (state_q == LOAD) && in_valid;
        len_bad     = cmd_len > DEPTH_L;
        len_zero    = cmd_len == '0;
        last_write  = wr_ptr_q == LAST_L;
        run_timeout = run_cnt_q == CNT_END;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_fire) begin
                if (len_bad)       state_d = DONE;
                else if (len_zero) state_d = RUN;
                else               state_d = LOAD;
            end
            LOAD: if (in_fire && last_write) state_d = RUN;
            RUN:  if (w_enable || run_timeout) state_d = DONE;
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command registers, write pointer, run counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            wr_ptr_q   <= '0;
            acc_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            run_cnt_q  <= '0;
        end else begin
            if (state_q == RUN) run_cnt_q <= run_cnt_q + CNT_W'(1);
            else                run_cnt_q <= '0;

            if (cmd_fire) begin
                // base is DEPTH-len; an out-of-range length never releases the kernel
                base_q     <= ADDR_W'(DEPTH_L - cmd_len);
                wr_ptr_q   <= DEPTH_L - cmd_len;
                acc_q      <= cmd_acc;
                res_data_q <= '0;
                res_err_q  <= len_bad;
            end

            if (in_fire) wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);

            if (state_q == RUN) begin
                if (w_enable) begin
                    res_data_q <= result;
                    res_err_q  <= 1'b0;
                end else if (run_timeout) begin
                    res_data_q <= '0;
                    res_err_q  <= 1'b1;
                end
            end
        end
    end

    // Output decode from state and handshakes
    always_comb begin
        cmd_ready           = (state_q == IDLE);
        in_ready            = (state_q == LOAD);
        controlArr          = (state_q == LOAD);
        r_enable            = (state_q != RUN);
        res_valid           = (state_q == DONE);
        res_data            = res_data_q;
        res_err             = res_err_q;
        init_i_t_a          = base_q;
        init_acc_t_a        = acc_q;
        controlArrWEnable_a = in_fire;
        controlArrWEnable_b = in_fire;
        controlArrAddr_a    = wr_ptr_q[ADDR_W-1:0];
        controlArrAddr_b    = wr_ptr_q[ADDR_W-1:0];
        controlArrWData_a   = in_a;
        controlArrWData_b   = in_b;
    end

endmodule

// File: tb/tb_dot_prod_host.sv
// Testbench for dot_prod_host: a behavioural kernel model (arrays, 3 cycles per
// element) sits behind the DUT; directed commands are checked against
// hand-computed results.
module tb_dot_prod_host;

    localparam int DEPTH   = 1000;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 27;
    localparam int RES_W   = 64;
    localparam int TIMEOUT = 4096;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready;
    logic [ADDR_W:0]   cmd_len;
    logic [RES_W-1:0]  cmd_acc;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_a, in_b;
    logic              res_valid, res_ready;
    logic [RES_W-1:0]  res_data;
    logic              res_err;
    logic              r_enable;
    logic [ADDR_W-1:0] init_i_t_a;
    logic [RES_W-1:0]  init_acc_t_a;
    logic              controlArr;
    logic              controlArrWEnable_a, controlArrWEnable_b;
    logic [ADDR_W-1:0] controlArrAddr_a, controlArrAddr_b;
    logic [DATA_W-1:0] controlArrWData_a, controlArrWData_b;
    logic              w_enable;
    logic [RES_W-1:0]  result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_prod_host #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_acc(cmd_acc),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .r_enable(r_enable), .init_i_t_a(init_i_t_a), .init_acc_t_a(init_acc_t_a),
        .controlArr(controlArr),
        .controlArrWEnable_a(controlArrWEnable_a), .controlArrWEnable_b(controlArrWEnable_b),
        .controlArrAddr_a(controlArrAddr_a), .controlArrAddr_b(controlArrAddr_b),
        .controlArrWData_a(controlArrWData_a), .controlArrWData_b(controlArrWData_b),
        .w_enable(w_enable), .result(result)
    );

    // ---------------- kernel model ----------------
    longint a_mem [DEPTH];
    longint b_mem [DEPTH];
    int     k_st, k_i, k_ph;
    longint k_acc;
    logic   k_done;
    logic   stuck = 1'b0;

    assign w_enable = k_done && !stuck;
    assign result   = k_acc;

    always @(posedge clk) begin
        if (controlArr && controlArrWEnable_a && int'(controlArrAddr_a) < DEPTH)
            a_mem[controlArrAddr_a] <= longint'($signed(controlArrWData_a));
        if (controlArr && controlArrWEnable_b && int'(controlArrAddr_b) < DEPTH)
            b_mem[controlArrAddr_b] <= longint'($signed(controlArrWData_b));
        if (r_enable) begin
            k_st   <= 0;
            k_done <= 1'b0;
        end else begin
            case (k_st)
                0: begin
                    k_i   <= int'(init_i_t_a);
                    k_acc <= $signed(init_acc_t_a);
                    k_ph  <= 0;
                    k_st  <= 1;
                end
                1: begin
                    if (k_i >= DEPTH) begin
                        k_done <= 1'b1;
                        k_st   <= 2;
                    end else if (k_ph == 2) begin
                        k_acc <= k_acc + a_mem[k_i] * b_mem[k_i];
                        k_i   <= k_i + 1;
                        k_ph  <= 0;
                    end else begin
                        k_ph <= k_ph + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write and activity monitors ----------------
    int wr_count = 0, first_addr = -1, last_addr = -1, viol = 0;
    bit seen_in_ready = 0, seen_run = 0;

    always @(posedge clk) begin
        if (controlArrWEnable_a || controlArrWEnable_b) begin
            if (!(controlArrWEnable_a && controlArrWEnable_b && controlArr &&
                  controlArrAddr_a == controlArrAddr_b && in_valid && in_ready))
                viol = viol + 1;
            if (wr_count == 0) first_addr = int'(controlArrAddr_a);
            last_addr = int'(controlArrAddr_a);
            wr_count  = wr_count + 1;
        end
    end

    always @(negedge clk) begin
        if (in_ready === 1'b1) seen_in_ready = 1;
        if (r_enable === 1'b0) seen_run = 1;
    end

    task automatic clear_log();
        wr_count = 0; first_addr = -1; last_addr = -1;
        seen_in_ready = 0; seen_run = 0;
    endtask

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send_cmd(input int len, input longint acc, output bit ok);
        ok = 0;
        cmd_len = (ADDR_W+1)'(len);
        cmd_acc = acc;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_pair(input longint a, input longint b, input bit stall, output bit ok);
        ok = 0;
        in_a = DATA_W'(a);
        in_b = DATA_W'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (stall) @(negedge clk);
    endtask

    task automatic recv(input int bound, output bit ok, output longint data,
                        output bit err, output int cyc);
        ok = 0; data = 0; err = 0; cyc = 0;
        res_ready = 1'b1;
        while (cyc < bound) begin
            if (res_valid) begin
                ok = 1;
                data = $signed(res_data);
                err = res_err;
                @(negedge clk);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        res_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        total++; if (res_valid !== 1'b0 || res_err !== 1'b0) begin bad++; $display("FAIL rst_res got valid=%b err=%b want 0 0", res_valid, res_err); end
        total++; if (res_data !== '0) begin bad++; $display("FAIL rst_res_data got %0d want 0", res_data); end
        total++; if (r_enable !== 1'b1 || controlArr !== 1'b0) begin bad++; $display("FAIL rst_ctrl got r_enable=%b controlArr=%b want 1 0", r_enable, controlArr); end
        total++; if (controlArrWEnable_a !== 1'b0 || controlArrWEnable_b !== 1'b0) begin bad++; $display("FAIL rst_wen got %b%b want 00", controlArrWEnable_a, controlArrWEnable_b); end
        total++; if (init_i_t_a !== '0 || init_acc_t_a !== '0) begin bad++; $display("FAIL rst_init got i=%0d acc=%0d want 0 0", init_i_t_a, init_acc_t_a); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok, err; longint d; int cyc;
        clear_log();
        send_cmd(3, 10, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_cmd got no handshake want handshake"); end
        total++; if (cmd_ready !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_load got cmd_ready=%b in_ready=%b want 0 1", cmd_ready, in_ready); end
        total++; if (init_i_t_a !== ADDR_W'(997)) begin bad++; $display("FAIL basic_init_i got %0d want 997", init_i_t_a); end
        send_pair(1, 2, 0, ok);
        send_pair(3, 4, 0, ok);
        send_pair(-5, 6, 0, ok);
        total++; if (wr_count != 3 || first_addr != 997 || last_addr != 999) begin bad++; $display("FAIL basic_addrs got n=%0d first=%0d last=%0d want 3 997 999", wr_count, first_addr, last_addr); end
        total++; if (a_mem[999] != -5 || b_mem[999] != 6 || a_mem[997] != 1 || b_mem[998] != 4) begin bad++; $display("FAIL basic_data got a999=%0d b999=%0d a997=%0d b998=%0d want -5 6 1 4", a_mem[999], b_mem[999], a_mem[997], b_mem[998]); end
        total++; if (r_enable !== 1'b0) begin bad++; $display("FAIL basic_run got r_enable=%b want 0", r_enable); end
        recv(100, ok, d, err, cyc);
        total++; if (!ok || d != -6 || err) begin bad++; $display("FAIL basic_result got ok=%0d data=%0d err=%0d want 1 -6 0", ok, d, err); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL basic_back_idle got cmd_ready=%b want 1", cmd_ready); end
    endtask

    task automatic test_len_zero();
        bit ok, err; longint d; int cyc;
        clear_log();
        send_cmd(0, -7, ok);
        recv(10, ok, d, err, cyc);
        total++; if (!ok || d != -7 || err) begin bad++; $display("FAIL zero_result got ok=%0d data=%0d err=%0d want 1 -7 0", ok, d, err); end
        total++; if (wr_count != 0 || seen_in_ready) begin bad++; $display("FAIL zero_no_load got writes=%0d in_ready_seen=%0d want 0 0", wr_count, seen_in_ready); end
    endtask

    task automatic test_bad_len();
        bit ok, err; longint d; int cyc;
        clear_log();
        in_valid = 1'b1;
        in_a = DATA_W'(9); in_b = DATA_W'(9);
        send_cmd(1001, 55, ok);
        recv(20, ok, d, err, cyc);
        in_valid = 1'b0;
        total++; if (!ok || d != 0 || !err) begin bad++; $display("FAIL badlen_result got ok=%0d data=%0d err=%0d want 1 0 1", ok, d, err); end
        total++; if (seen_in_ready || wr_count != 0) begin bad++; $display("FAIL badlen_no_load got in_ready_seen=%0d writes=%0d want 0 0", seen_in_ready, wr_count); end
        total++; if (seen_run) begin bad++; $display("FAIL badlen_kernel got released=%0d want 0", seen_run); end
    endtask

    task automatic test_full();
        bit ok, err; longint d, d0; int cyc, w;
        clear_log();
        send_cmd(1000, 0, ok);
        for (int i = 0; i < 1000; i++) send_pair(i, i, (i % 2) == 0, ok);
        total++; if (wr_count != 1000 || first_addr != 0 || last_addr != 999) begin bad++; $display("FAIL full_addrs got n=%0d first=%0d last=%0d want 1000 0 999", wr_count, first_addr, last_addr); end
        res_ready = 1'b0;
        w = 0;
        while (!res_valid && w < 6000) begin @(negedge clk); w++; end
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL full_wait got res_valid=%b want 1", res_valid); end
        d0 = $signed(res_data);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (res_valid !== 1'b1 || $signed(res_data) != d0) begin bad++; $display("FAIL full_hold got valid=%b data=%0d want 1 %0d", res_valid, $signed(res_data), d0); end
        end
        recv(5, ok, d, err, cyc);
        total++; if (!ok || d != 64'sd332833500 || err) begin bad++; $display("FAIL full_result got ok=%0d data=%0d err=%0d want 1 332833500 0", ok, d, err); end
    endtask

    task automatic test_timeout();
        bit ok, err; longint d; int cyc, n;
        stuck = 1'b1;
        send_cmd(0, 5, ok);
        total++; if (r_enable !== 1'b0) begin bad++; $display("FAIL timeout_run got r_enable=%b want 0", r_enable); end
        n = 0;
        while (!res_valid && n < 5000) begin @(negedge clk); n++; end
        total++; if (n != TIMEOUT) begin bad++; $display("FAIL timeout_cycles got %0d want %0d", n, TIMEOUT); end
        recv(5, ok, d, err, cyc);
        total++; if (!ok || d != 0 || !err) begin bad++; $display("FAIL timeout_result got ok=%0d data=%0d err=%0d want 1 0 1", ok, d, err); end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        bit ok, err; longint d; int cyc;
        send_cmd(5, 100, ok);
        send_pair(7, 7, 0, ok);
        send_pair(8, 8, 0, ok);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        total++; if (r_enable !== 1'b1 || controlArr !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got r_enable=%b controlArr=%b in_ready=%b want 1 0 0", r_enable, controlArr, in_ready); end
        total++; if (controlArrWEnable_a !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_state got wen=%b cmd_ready=%b want 0 1", controlArrWEnable_a, cmd_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        send_cmd(2, 0, ok);
        send_pair(2, 3, 0, ok);
        send_pair(4, 5, 1, ok);
        total++; if (wr_count != 2 || first_addr != 998 || last_addr != 999) begin bad++; $display("FAIL midrst_addrs got n=%0d first=%0d last=%0d want 2 998 999", wr_count, first_addr, last_addr); end
        recv(100, ok, d, err, cyc);
        total++; if (!ok || d != 26 || err) begin bad++; $display("FAIL midrst_result got ok=%0d data=%0d err=%0d want 1 26 0", ok, d, err); end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_len = '0; cmd_acc = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_bad_len();
        test_full();
        test_timeout();
        test_reset_mid_load();
        total++; if (viol != 0) begin bad++; $display("FAIL write_protocol got %0d stray writes want 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
